// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small byte FIFO and valid/ready output.
// Sticky frame_err/overrun flags; neither flag blocks further reception.
module uart_rx_fifo #(
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int TW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);

  localparam logic [TW-1:0] T_HALF  = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic         rx_m;
  logic         rx_s;

  state_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         push;
  logic         ferr_set;

  logic [7:0]   mem [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         empty;
  logic         full;
  logic         pop;
  logic         push_ok;
  logic         ovr_set;

  // Two-flop synchronizer, reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; the shift register is updated here so the full byte
  // is already in shreg_q when the stop bit is sampled.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + T_ONE;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          timer_d        = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // FIFO status; a pop in the same cycle frees the slot a full-FIFO push needs.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign rx_data  = rx_valid ? mem[rptr_q[AW-1:0]] : '0;

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q[AW-1:0]] <= shreg_q;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a new event in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard.
module tb_uart_rx_fifo;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      drive_bit(d[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_head(d);
    drive_bit(stop);
  endtask

  // Compare head against scoreboard at a negedge, then pop it for one edge.
  task automatic pop_check(input string tag);
    @(negedge clk);
    chk1(tag, rx_valid, 1'b1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%02h expected=<scoreboard empty>", tag, rx_data);
    end else begin
      chk8(tag, rx_data, exp_q.pop_front());
    end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int unsigned err_cnt;
    logic        saw_busy;

    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_valid", rx_valid, 1'b0);
    chk8("rst_data", rx_data, 8'h00);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) step();

    // Single byte with exact push timing.
    exp_q.push_back(8'hA5);
    send_head(8'hA5);
    rx = 1'b1;
    repeat (DIV / 2 + 2) @(posedge clk);
    @(negedge clk);
    chk1("a5_pre_busy", busy, 1'b1);
    chk1("a5_pre_valid", rx_valid, 1'b0);
    @(negedge clk);
    chk1("a5_push_busy", busy, 1'b0);
    chk1("a5_push_valid", rx_valid, 1'b1);
    pop_check("a5_data");
    @(negedge clk);
    chk1("a5_after_pop_valid", rx_valid, 1'b0);
    step();

    // Start-bit glitch.
    rx = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk1("glitch_saw_busy", saw_busy, 1'b1);
    chk1("glitch_busy_end", busy, 1'b0);
    chk1("glitch_valid", rx_valid, 1'b0);
    chk1("glitch_ferr", frame_err, 1'b0);
    step();

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    chk1("frm_ferr", frame_err, 1'b1);
    chk1("frm_valid", rx_valid, 1'b0);
    chk1("frm_busy", busy, 1'b1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    err_cnt = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_err) err_cnt++;
    end
    chk8("frm_break_no_reflag", 8'(err_cnt), 8'd0);
    step();
    rx = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk1("frm_release_busy", busy, 1'b0);
    chk1("frm_release_valid", rx_valid, 1'b0);
    step();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    pop_check("frm_next_11");
    step();

    // Overrun with consumer stalled.
    for (int unsigned v = 1; v <= 5; v++) begin
      if (v <= DEPTH) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
      if (v == DEPTH) begin
        @(negedge clk);
        chk1("ovr_full_no_flag", overrun, 1'b0);
        step();
      end
    end
    @(negedge clk);
    chk1("ovr_flag", overrun, 1'b1);
    step();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pop_check("ovr_data");
    end
    @(negedge clk);
    chk1("ovr_drained_valid", rx_valid, 1'b0);
    step();

    // err_clr clears both flags.
    send_frame(8'h77, 1'b0);
    rx = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk1("clr_pre_ferr", frame_err, 1'b1);
    chk1("clr_pre_ovr", overrun, 1'b1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk1("clr_ferr", frame_err, 1'b0);
    chk1("clr_ovr", overrun, 1'b0);
    step();

    // Full FIFO with a pop in the push cycle.
    for (int unsigned v = 8'h10; v <= 8'h13; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    send_head(8'h14);
    rx = 1'b1;
    repeat (DIV / 2 + 2) @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(negedge clk);
    chk1("simul_busy", busy, 1'b1);
    chk8("simul_head", rx_data, exp_q.pop_front());
    exp_q.push_back(8'h14);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk1("simul_ovr", overrun, 1'b0);
    chk1("simul_busy_end", busy, 1'b0);
    step();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pop_check("simul_data");
    end
    @(negedge clk);
    chk1("simul_drained_valid", rx_valid, 1'b0);
    step();

    // err_clr in the same cycle as a new framing error.
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk1("setwin_pre_ferr", frame_err, 1'b1);
    step();
    send_head(8'h66);
    rx = 1'b0;
    repeat (DIV / 2 + 2) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk1("setwin_ferr", frame_err, 1'b1);
    step();
    rx = 1'b1;
    repeat (4) step();

    // Reset in the middle of a frame, with a byte buffered and a flag set.
    send_frame(8'h42, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    chk1("mid_pre_busy", busy, 1'b1);
    chk1("mid_pre_valid", rx_valid, 1'b1);
    step();
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk1("mid_rst_valid", rx_valid, 1'b0);
    chk8("mid_rst_data", rx_data, 8'h00);
    chk1("mid_rst_ferr", frame_err, 1'b0);
    chk1("mid_rst_ovr", overrun, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    pop_check("post_rst_5a");
    @(negedge clk);
    chk1("post_rst_valid", rx_valid, 1'b0);
    chk1("post_rst_ferr", frame_err, 1'b0);
    chk1("post_rst_ovr", overrun, 1'b0);
    chk8("sb_leftover", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
